spad_fifo_replay: RTL and testbench
===================================

# spad_fifo_replay

Single-clock, parametrised scratchpad FIFO for the PE datapath. It succeeds the dual-clock pointer FIFO with the following additions:
- full/empty flags and occupancy;
- overflow/underflow protection;
- a mark/rewind/release replay mechanism, so a PE can re-stream a filter or ifmap row without refilling it.

It sits between the GLB-side loader (write side) and the PE MAC pipeline (read side).

## Interface
Parameters:
- DATA_WIDTH, 16, word width
- DEPTH, 12, entries; any value ≥ 2, power of two not required
- ADDR_WIDTH, $clog2(DEPTH), pointer width (derived)
- CNT_WIDTH, $clog2(DEPTH+1), occupancy width (derived)

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- rd_en  in  1  read request
- rd_inc  in  1  with an accepted read: 1 = pop, 0 = peek (pointer unchanged)
- mark  in  1  capture current read pointer as replay point
- rewind  in  1  restore read pointer to replay point
- release  in  1  drop replay point, free retained entries
- rd_data  out  DATA_WIDTH  registered read word
- rd_dvalid  out  1  rd_data valid this cycle
- full  out  1  used == DEPTH
- empty  out  1  avail == 0
- used  out  CNT_WIDTH  entries occupied (retained + unread)
- avail  out  CNT_WIDTH  entries readable
- err  out  1  one-cycle pulse on a refused write (full) or refused read (empty)

## Operation
State:
- storage mem[DEPTH], wr_ptr, rd_ptr, mark_ptr, mark_active, used, avail.

Reset:
- wr_ptr = rd_ptr = mark_ptr = 0; mark_active = 0; used = avail = 0.
- Outputs: rd_data = 0, rd_dvalid = 0, err = 0, full = 0, empty = 1.

Write:
- Accepted iff wr_en && !full.
- mem[wr_ptr] <= wr_data; wr_ptr advances; used +1; avail +1.
- A pop in the same cycle does not unblock a full write.

Read:
- Accepted iff rd_en && !empty && !rewind.
- rd_data <= mem[rd_ptr] (the value before this cycle's write); rd_dvalid <= 1.
- If rd_inc: rd_ptr advances and avail −1. If also !mark_active: used −1.
- No write-to-read bypass: a read is refused when empty, even if a write lands in the same cycle.

Idle read cycles:
- On any cycle without an accepted read, rd_data <= 0 and rd_dvalid <= 0.

err:
- Pulses when wr_en && full, or when rd_en && empty && !rewind.

Pointer arithmetic:
- Pointers wrap explicitly: DEPTH−1 → 0. Never rely on modulo-2^ADDR_WIDTH.

Mark:
- mark_ptr <= rd_ptr as it stood at the start of the cycle (pre-pop); mark_active <= 1.
- A re-mark while already active moves the point: used <= used − (retained entries between the old and new mark).
- Retained region = used − avail entries between mark_ptr and rd_ptr. The write side cannot overwrite it; full accounts for it.

Rewind:
- Only when mark_active; otherwise ignored.
- rd_ptr <= mark_ptr; avail <= used (+1 if a write is accepted the same cycle).
- Rewind has priority over a read: a read in the same cycle is neither performed nor flagged as an error.

Release:
- mark_active <= 0; used <= avail (±write/pop this cycle).

Simultaneous events:
- rewind + release: rewind applies first, then release, so used = avail = pre-release used.
- mark + release: mark wins.
- mark + rewind: rewind wins; the mark is ignored.

Reset mid-operation:
- rst overrides all requests in that cycle; all contents become unreadable.

## Timing
- Write-to-readable latency: data written in cycle N is readable from cycle N+1 (avail updates at the N+1 edge).
- Read latency: 1 cycle. Request in cycle N gives rd_data/rd_dvalid in cycle N+1.
- Peek and pop both support back-to-back reads every cycle.
- full, empty, used and avail are registered and reflect all events of the previous cycle.
- A rewind in cycle N makes the first replayed word requestable in cycle N+1; data appears in N+2.
- Throughput: one write and one read per cycle, sustained.

## Test plan
- Reset, then write 1..12 with DEPTH=12: full=1 and used=12 after the 12th. A 13th write gives err=1 with contents unchanged. Pop all 12: rd_data = 1..12 in order, one cycle after each rd_en, then empty=1.
- Wrap: DEPTH=12. Write 8, pop 8, write 8 more (values 100..107), pop 8: output is 100..107, and pointers pass 11→0 correctly.
- Peek: write 5,6. rd_en with rd_inc=0 three times gives 5,5,5. rd_inc=1 gives 5 then 6. avail goes 2→2→2→2→1→0.
- Replay: write 10..13, mark, pop 4 (used=4, avail=0), rewind, pop 4: again 10..13. Release: used=0, then 12 more writes are accepted.
- Retention blocks writes: DEPTH=12. Write 12, mark, pop 12: full stays 1 and a write is refused with err=1. After release, full=0 and the write is accepted.
- Simultaneous: rewind+rd_en in the same cycle gives no rd_dvalid next cycle and err=0. rst asserted during a streaming pop gives rd_dvalid=0, empty=1, used=0 next cycle.

Source files
------------

// File: rtl/spad_fifo_replay.sv
// spad_fifo_replay: single-clock scratchpad FIFO between the GLB loader and
// the PE MAC pipeline, with occupancy flags and mark/rewind/release replay.
//
// Ports:
//   clk          clock, all logic on posedge
//   rst          synchronous active-high reset
//   wr_en        write request
//   wr_data      write word
//   rd_en        read request
//   rd_inc       with an accepted read: 1 = pop, 0 = peek
//   mark         capture current read pointer as replay point
//   rewind       restore read pointer to replay point
//   release_mark drop replay point, free retained entries
//   rd_data      registered read word (0 when no read)
//   rd_dvalid    rd_data valid this cycle
//   full         used == DEPTH
//   empty        avail == 0
//   used         entries occupied (retained + unread)
//   avail        entries readable
//   err          one-cycle pulse on a refused write or refused read
module spad_fifo_replay #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 12,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  rd_inc,
    input  logic                  mark,
    input  logic                  rewind,
    input  logic                  release_mark,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_dvalid,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_WIDTH-1:0]  used,
    output logic [CNT_WIDTH-1:0]  avail,
    output logic                  err
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] mark_ptr;
    logic                  mark_active;

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  pop;
    logic                  rew_eff;
    logic                  mark_eff;
    logic                  rel_eff;
    logic [CNT_WIDTH-1:0]  wr_c;
    logic [CNT_WIDTH-1:0]  pop_c;

    logic [ADDR_WIDTH-1:0] wr_ptr_n;
    logic [ADDR_WIDTH-1:0] rd_ptr_n;
    logic [ADDR_WIDTH-1:0] mark_ptr_n;
    logic                  mark_active_n;
    logic [CNT_WIDTH-1:0]  used_n;
    logic [CNT_WIDTH-1:0]  avail_n;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(
        input logic [ADDR_WIDTH-1:0] p
    );
        if (p == ADDR_WIDTH'(DEPTH - 1))
            return '0;
        return p + ADDR_WIDTH'(1);
    endfunction

    always_comb begin
        wr_acc   = wr_en && !full;
        // Rewind pre-empts any read, even when it has no mark to act on.
        rd_acc   = rd_en && !empty && !rewind;
        pop      = rd_acc && rd_inc;
        rew_eff  = rewind && mark_active;
        mark_eff = mark && !rew_eff;
        rel_eff  = release_mark && !mark_eff;
        wr_c     = {{(CNT_WIDTH-1){1'b0}}, wr_acc};
        pop_c    = {{(CNT_WIDTH-1){1'b0}}, pop};
    end

    always_comb begin
        wr_ptr_n      = wr_acc ? ptr_inc(wr_ptr) : wr_ptr;
        rd_ptr_n      = rd_ptr;
        mark_ptr_n    = mark_ptr;
        mark_active_n = mark_active;
        used_n        = used;
        avail_n       = avail + wr_c - pop_c;

        if (rew_eff) begin
            rd_ptr_n = mark_ptr;
            avail_n  = used + wr_c;
        end else if (pop) begin
            rd_ptr_n = ptr_inc(rd_ptr);
        end

        if (rew_eff) begin
            // Release (if any) leaves used == avail == replayed region.
            used_n = used + wr_c;
        end else if (mark_eff) begin
            // New mark sits at the pre-pop read pointer: everything still
            // readable stays retained, older retained entries are freed.
            used_n = avail + wr_c;
        end else if (rel_eff) begin
            used_n = avail + wr_c - pop_c;
        end else if (mark_active) begin
            used_n = used + wr_c;
        end else begin
            used_n = used + wr_c - pop_c;
        end

        if (mark_eff) begin
            mark_ptr_n    = rd_ptr;
            mark_active_n = 1'b1;
        end else if (rel_eff) begin
            mark_active_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mark_ptr    <= '0;
            mark_active <= 1'b0;
            used        <= '0;
            avail       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            rd_data     <= '0;
            rd_dvalid   <= 1'b0;
            err         <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_n;
            rd_ptr      <= rd_ptr_n;
            mark_ptr    <= mark_ptr_n;
            mark_active <= mark_active_n;
            used        <= used_n;
            avail       <= avail_n;
            full        <= (used_n == CNT_WIDTH'(DEPTH));
            empty       <= (avail_n == '0);
            rd_data     <= rd_acc ? mem[rd_ptr] : '0;
            rd_dvalid   <= rd_acc;
            err         <= (wr_en && full) ||
                           (rd_en && empty && !rewind);
        end
    end

endmodule

// File: tb/tb_spad_fifo_replay.sv
// tb_spad_fifo_replay: scenario tasks drive the FIFO; read data is checked
// by a negedge monitor against a queue of expected words.
module tb_spad_fifo_replay;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        rd_en;
    logic        rd_inc;
    logic        mark;
    logic        rewind;
    logic        release_mark;
    logic [15:0] rd_data;
    logic        rd_dvalid;
    logic        full;
    logic        empty;
    logic [3:0]  used;
    logic [3:0]  avail;
    logic        err;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] sb [$];
    logic [15:0] exp_w;

    spad_fifo_replay #(.DATA_WIDTH(16), .DEPTH(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_inc       (rd_inc),
        .mark         (mark),
        .rewind       (rewind),
        .release_mark (release_mark),
        .rd_data      (rd_data),
        .rd_dvalid    (rd_dvalid),
        .full         (full),
        .empty        (empty),
        .used         (used),
        .avail        (avail),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_dvalid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL rd_data unexpected: got %0d, none queued",
                         rd_data);
            end else begin
                exp_w = sb.pop_front();
                if (rd_data !== exp_w) begin
                    n_bad++;
                    $display("FAIL rd_data: got %0d want %0d",
                             rd_data, exp_w);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; rd_en = 0; rd_inc = 0;
        mark = 0; rewind = 0; release_mark = 0; rst = 0;
    endtask

    task automatic test_reset();
        idle(); wr_data = 0; rst = 1;
        cyc(); cyc();
        rst = 0;
        n_cmp++;
        if (rd_data !== 16'd0) begin
            n_bad++; $display("FAIL reset rd_data: got %0d want 0", rd_data);
        end
        n_cmp++;
        if (rd_dvalid !== 1'b0) begin
            n_bad++; $display("FAIL reset rd_dvalid: got %b want 0", rd_dvalid);
        end
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL reset err: got %b want 0", err);
        end
        n_cmp++;
        if (full !== 1'b0 || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL reset flags: got full=%b empty=%b want 0 1",
                     full, empty);
        end
        n_cmp++;
        if (used !== 4'd0 || avail !== 4'd0) begin
            n_bad++;
            $display("FAIL reset counts: got used=%0d avail=%0d want 0 0",
                     used, avail);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 12; i++) begin
            wr_en = 1; wr_data = 16'(i);
            cyc();
        end
        n_cmp++;
        if (full !== 1'b1 || used !== 4'd12) begin
            n_bad++;
            $display("FAIL fill full/used: got %b/%0d want 1/12", full, used);
        end
        wr_data = 16'd99;
        cyc();
        wr_en = 0;
        n_cmp++;
        if (err !== 1'b1 || used !== 4'd12) begin
            n_bad++;
            $display("FAIL overflow err/used: got %b/%0d want 1/12", err, used);
        end
        for (int i = 1; i <= 12; i++) begin
            rd_en = 1; rd_inc = 1; sb.push_back(16'(i));
            cyc();
        end
        idle();
        cyc();
        n_cmp++;
        if (empty !== 1'b1 || used !== 4'd0 || full !== 1'b0) begin
            n_bad++;
            $display("FAIL drain flags: got empty=%b used=%0d full=%b want 1 0 0",
                     empty, used, full);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL drain pending: got %0d want 0", sb.size());
        end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) begin
                wr_en = 1; wr_data = 16'((r == 0 ? 50 : 100) + i);
                cyc();
            end
            wr_en = 0;
            for (int i = 0; i < 8; i++) begin
                rd_en = 1; rd_inc = 1;
                sb.push_back(16'((r == 0 ? 50 : 100) + i));
                cyc();
            end
            idle();
        end
        cyc();
        n_cmp++;
        if (sb.size() != 0 || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap: got pending=%0d empty=%b want 0 1",
                     sb.size(), empty);
        end
    endtask

    task automatic test_peek();
        wr_en = 1; wr_data = 16'd5; cyc();
        wr_data = 16'd6; cyc();
        wr_en = 0;
        n_cmp++;
        if (avail !== 4'd2) begin
            n_bad++; $display("FAIL peek avail0: got %0d want 2", avail);
        end
        for (int k = 0; k < 3; k++) begin
            rd_en = 1; rd_inc = 0; sb.push_back(16'd5);
            cyc();
            n_cmp++;
            if (avail !== 4'd2) begin
                n_bad++; $display("FAIL peek avail: got %0d want 2", avail);
            end
        end
        rd_inc = 1; sb.push_back(16'd5); cyc();
        n_cmp++;
        if (avail !== 4'd1) begin
            n_bad++; $display("FAIL pop avail1: got %0d want 1", avail);
        end
        sb.push_back(16'd6); cyc();
        n_cmp++;
        if (avail !== 4'd0 || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL pop avail0: got %0d/%b want 0/1", avail, empty);
        end
        idle(); cyc();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL peek pending: got %0d want 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        wr_en = 1; wr_data = 16'd40; cyc();
        for (int i = 1; i <= 5; i++) begin
            wr_data = 16'(40 + i);
            rd_en = 1; rd_inc = 1; sb.push_back(16'(40 + i - 1));
            cyc();
            n_cmp++;
            if (avail !== 4'd1) begin
                n_bad++; $display("FAIL b2b avail: got %0d want 1", avail);
            end
        end
        wr_en = 0; sb.push_back(16'd45); cyc();
        idle(); cyc();
        n_cmp++;
        if (used !== 4'd0 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL b2b end: got used=%0d pending=%0d want 0 0",
                     used, sb.size());
        end
    endtask

    task automatic test_replay();
        int errs;
        for (int i = 10; i <= 13; i++) begin
            wr_en = 1; wr_data = 16'(i); cyc();
        end
        wr_en = 0;
        mark = 1; cyc(); mark = 0;
        for (int i = 10; i <= 13; i++) begin
            rd_en = 1; rd_inc = 1; sb.push_back(16'(i)); cyc();
        end
        idle();
        n_cmp++;
        if (used !== 4'd4 || avail !== 4'd0) begin
            n_bad++;
            $display("FAIL replay retain: got used=%0d avail=%0d want 4 0",
                     used, avail);
        end
        rewind = 1; cyc(); rewind = 0;
        n_cmp++;
        if (avail !== 4'd4) begin
            n_bad++; $display("FAIL rewind avail: got %0d want 4", avail);
        end
        for (int i = 10; i <= 13; i++) begin
            rd_en = 1; rd_inc = 1; sb.push_back(16'(i)); cyc();
        end
        idle();
        release_mark = 1; cyc(); release_mark = 0;
        n_cmp++;
        if (used !== 4'd0 || avail !== 4'd0) begin
            n_bad++;
            $display("FAIL release counts: got used=%0d avail=%0d want 0 0",
                     used, avail);
        end
        errs = 0;
        for (int i = 0; i < 12; i++) begin
            wr_en = 1; wr_data = 16'(200 + i); cyc();
            if (err === 1'b1) errs++;
        end
        wr_en = 0;
        n_cmp++;
        if (errs != 0 || used !== 4'd12 || full !== 1'b1) begin
            n_bad++;
            $display("FAIL refill: got errs=%0d used=%0d full=%b want 0 12 1",
                     errs, used, full);
        end
        for (int i = 0; i < 12; i++) begin
            rd_en = 1; rd_inc = 1; sb.push_back(16'(200 + i)); cyc();
        end
        idle(); cyc();
        n_cmp++;
        if (sb.size() != 0 || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL replay end: got pending=%0d empty=%b want 0 1",
                     sb.size(), empty);
        end
    endtask

    task automatic test_retention();
        for (int i = 0; i < 12; i++) begin
            wr_en = 1; wr_data = 16'(300 + i); cyc();
        end
        wr_en = 0;
        mark = 1; cyc(); mark = 0;
        for (int i = 0; i < 12; i++) begin
            rd_en = 1; rd_inc = 1; sb.push_back(16'(300 + i)); cyc();
        end
        idle();
        n_cmp++;
        if (full !== 1'b1 || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL retain flags: got full=%b empty=%b want 1 1",
                     full, empty);
        end
        wr_en = 1; wr_data = 16'd999; cyc(); wr_en = 0;
        n_cmp++;
        if (err !== 1'b1 || used !== 4'd12) begin
            n_bad++;
            $display("FAIL retain write: got err=%b used=%0d want 1 12",
                     err, used);
        end
        release_mark = 1; cyc(); release_mark = 0;
        n_cmp++;
        if (full !== 1'b0 || used !== 4'd0) begin
            n_bad++;
            $display("FAIL retain release: got full=%b used=%0d want 0 0",
                     full, used);
        end
        wr_en = 1; wr_data = 16'd777; cyc(); wr_en = 0;
        n_cmp++;
        if (err !== 1'b0 || used !== 4'd1) begin
            n_bad++;
            $display("FAIL post-release write: got err=%b used=%0d want 0 1",
                     err, used);
        end
        rd_en = 1; rd_inc = 1; sb.push_back(16'd777); cyc();
        idle(); cyc();
        n_cmp++;
        if (sb.size() != 0 || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL retain end: got pending=%0d empty=%b want 0 1",
                     sb.size(), empty);
        end
    endtask

    task automatic test_simultaneous();
        wr_en = 1; wr_data = 16'd1; cyc();
        wr_data = 16'd2; cyc(); wr_en = 0;
        mark = 1; cyc(); mark = 0;
        rewind = 1; rd_en = 1; rd_inc = 1; cyc();
        idle();
        n_cmp++;
        if (rd_dvalid !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL rewind+read: got dvalid=%b err=%b want 0 0",
                     rd_dvalid, err);
        end
        release_mark = 1; cyc(); release_mark = 0;
        n_cmp++;
        if (used !== 4'd2 || avail !== 4'd2) begin
            n_bad++;
            $display("FAIL sim release: got used=%0d avail=%0d want 2 2",
                     used, avail);
        end
        for (int i = 20; i <= 23; i++) begin
            wr_en = 1; wr_data = 16'(i); cyc();
        end
        wr_en = 0;
        rd_en = 1; rd_inc = 1;
        sb.push_back(16'd1); cyc();
        sb.push_back(16'd2); cyc();
        sb.push_back(16'd20); cyc();
        rst = 1; cyc();
        idle();
        n_cmp++;
        if (rd_dvalid !== 1'b0 || empty !== 1'b1 || used !== 4'd0) begin
            n_bad++;
            $display("FAIL mid reset: got dvalid=%b empty=%b used=%0d want 0 1 0",
                     rd_dvalid, empty, used);
        end
        cyc();
        n_cmp++;
        if (sb.size() != 0 || avail !== 4'd0) begin
            n_bad++;
            $display("FAIL mid reset end: got pending=%0d avail=%0d want 0 0",
                     sb.size(), avail);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_peek();
        test_back_to_back();
        test_replay();
        test_retention();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
